fft8_ahb_master: RTL and testbench
==================================

// Module: fft8_ahb_master
// PURPOSE
// AHB-Lite initiator that drives the FFT8 peripheral on the system bus. It writes 8 complex
// samples from a local buffer to the peripheral's word slots, waits a fixed compute interval,
// then reads the 8 results back and streams them out. Used as a DMA-style front end and as
// the bus-side driver in FFT system tests. Single master, one outstanding transfer.
// PARAMETERS
// BASE_ADDR       32'h5000_0000  peripheral base; slot i at BASE_ADDR + 4*i (haddr[4:2]=i)
// WAIT_CYCLES     16             idle cycles between last write and first read (FFT latency)
// TIMEOUT_CYCLES  64             max data-phase cycles with hready=0 before error abort
// PORTS
// pclk       in   1    clock; all state on rising edge
// preset     in   1    reset, asynchronous, active-low
// master0    ahblite_interconnection.ahblite_master  haddr,htrans,hwrite,hsize,hwdata out; hrdata,hready,hresp in
// start      in   1    one-cycle pulse; ignored unless busy=0
// busy       out  1    high from cycle after accepted start until done/err
// done       out  1    one-cycle pulse after 8th result delivered
// err        out  1    one-cycle pulse on hresp=1 or timeout; run aborted
// load_we    in   1    writes load_data to buffer slot load_idx; ignored while busy=1
// load_idx   in   3    buffer slot 0..7
// load_data  in   32   complex sample {re[15:0], im[15:0]}
// res_valid  out  1    one-cycle pulse per result read
// res_idx    out  3    result slot 0..7
// res_data   out  32   complex result {re[31:16], im[15:0]} as on hrdata
// BEHAVIOUR
// - Reset: busy/done/err/res_valid=0, res_idx=0, res_data=0, htrans=IDLE, haddr=0, hwrite=0,
//   hsize=3'b010, hwdata=0, buffer=0, FSM=IDLE, counters=0. Reset mid-run aborts immediately.
// - FSM: IDLE -> W_ADDR -> W_DATA -> W_GAP -> (idx<7: W_ADDR idx+1 | idx=7: COMPUTE)
//   -> R_ADDR -> R_DATA -> R_GAP -> (idx<7: R_ADDR idx+1 | idx=7: IDLE with done).
// - *_ADDR: exactly one cycle; htrans=NONSEQ, haddr=BASE_ADDR+{idx,2'b00}, hwrite=1 (W)/0 (R).
// - All other states: htrans=IDLE, haddr=0, hwrite=0.
// - *_DATA: wait for hready=1; transfer completes at that edge; hresp=1 with hready -> err.
//   In R_DATA, sample hrdata at completion: res_data=hrdata, res_idx=idx, res_valid pulses next cycle.
// - hwdata = buffer[idx] from W_ADDR exit until W_GAP exit (held through DATA and GAP).
// - *_GAP: one mandatory idle cycle so the peripheral deselects and commits the write.
// - Zero-wait slave: 3 cycles per transfer; run = 24 + WAIT_CYCLES + 24 cycles.
// - COMPUTE: counts WAIT_CYCLES cycles, then R_ADDR idx=0. WAIT_CYCLES=0 goes direct.
// - Timeout counter clears on entering *_DATA; reaching TIMEOUT_CYCLES with hready=0 -> err.
// - Error: err pulse, FSM=IDLE, busy=0, htrans=IDLE; no done, no further res_valid.
// - start with busy=1 is ignored. start and load_we in the same IDLE cycle: both take effect;
//   the load is visible to the run.
// - done and res_valid for slot 7: res_valid in the R_GAP cycle, done one cycle later with busy->0.
// - Buffer is not cleared by a run; back-to-back runs resend the same samples.
// STRUCTURE
// - fft8_ahb_pkg: state_e enum, HTRANS_IDLE/NONSEQ, HSIZE_WORD constants; existing complex typedef.
// - Sub-module fft8_sample_buf: 8x32 register file, async-reset, 1 write port, 1 read port.
// - Top: FSM, idx counter (3b), wait/timeout counter, output registers.
// TESTING
// - Load slots i = {16'(i+1), 16'(-i)}, start, zero-wait slave model -> 8 NONSEQ writes to
//   0x5000_0000..0x5000_001C with matching hwdata; first read address phase exactly 24+16 cycles
//   after the first write address phase.
// - Full system with FFT8 peripheral, impulse input (slot0 = 0x0100_0000, others 0) ->
//   8 res_valid, each res_data = 0x0100_0000, res_idx 0..7 in order, then done.
// - Slave inserts 3 wait states on write 2 and read 5 -> hwdata held stable; timing shifts by 3
//   cycles each; all data correct.
// - hresp=1 on read 3 -> err pulse, busy=0, res_valid only for idx 0..2, no done.
// - hready stuck low in W_DATA for 64 cycles -> err on timeout; next start runs cleanly.
// - preset low mid-COMPUTE -> all outputs and buffer 0; start during busy and load_we during
//   busy -> no effect.

Source files
------------

// File: rtl/fft8_ahb_pkg.sv
// Shared types and bus encodings for the FFT8 AHB-Lite initiator.
package fft8_ahb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W_ADDR  = 3'd1,
    ST_W_DATA  = 3'd2,
    ST_W_GAP   = 3'd3,
    ST_COMPUTE = 3'd4,
    ST_R_ADDR  = 3'd5,
    ST_R_DATA  = 3'd6,
    ST_R_GAP   = 3'd7
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

endpackage

// File: rtl/ahblite_interconnection.sv
// AHB-Lite single-master bus bundle with initiator and target views.
interface ahblite_interconnection;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  modport ahblite_master (
    output haddr, htrans, hwrite, hsize, hwdata,
    input  hrdata, hready, hresp
  );

  modport ahblite_slave (
    input  haddr, htrans, hwrite, hsize, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/fft8_sample_buf.sv
// 8-entry complex sample store: one write port, one combinational read port.
module fft8_sample_buf
  import fft8_ahb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [2:0]  widx_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  ridx_i,
  output logic [31:0] rdata_o
);

  cplx_t mem_q [8];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/fft8_ahb_master.sv
// AHB-Lite initiator: writes 8 samples to the FFT8 peripheral, waits, reads 8 results back.
module fft8_ahb_master
  import fft8_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h5000_0000,
  parameter int unsigned WAIT_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        pclk,
  input  logic        preset,
  ahblite_interconnection.ahblite_master master0,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        load_we,
  input  logic [2:0]  load_idx,
  input  logic [31:0] load_data,
  output logic        res_valid,
  output logic [2:0]  res_idx,
  output logic [31:0] res_data
);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] res_data_q, res_data_d;
  logic [2:0]  res_idx_q, res_idx_d;
  logic        res_valid_q, res_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] buf_rdata;

  // Loads are locked out for the whole run so the samples cannot change mid-transfer.
  fft8_sample_buf u_buf (
    .clk_i   (pclk),
    .rst_ni  (preset),
    .we_i    (load_we && (state_q == ST_IDLE)),
    .widx_i  (load_idx),
    .wdata_i (load_data),
    .ridx_i  (idx_q),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    hwdata_d    = hwdata_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    res_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_W_ADDR;
          idx_d   = 3'd0;
        end
      end
      ST_W_ADDR: begin
        hwdata_d = buf_rdata;
        cnt_d    = '0;
        state_d  = ST_W_DATA;
      end
      ST_R_ADDR: begin
        cnt_d   = '0;
        state_d = ST_R_DATA;
      end
      ST_W_DATA, ST_R_DATA: begin
        if (master0.hready) begin
          if (master0.hresp) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (state_q == ST_W_DATA) begin
            state_d = ST_W_GAP;
          end else begin
            state_d     = ST_R_GAP;
            res_valid_d = 1'b1;
            res_idx_d   = idx_q;
            res_data_d  = master0.hrdata;
          end
        end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_W_GAP: begin
        if (idx_q == 3'd7) begin
          idx_d   = 3'd0;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? ST_R_ADDR : ST_COMPUTE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_W_ADDR;
        end
      end
      ST_COMPUTE: begin
        if (cnt_q == WAIT_CYCLES - 1) state_d = ST_R_ADDR;
        else                          cnt_d   = cnt_q + 32'd1;
      end
      ST_R_GAP: begin
        if (idx_q == 3'd7) begin
          idx_d   = 3'd0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_R_ADDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      hwdata_q    <= '0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      hwdata_q    <= hwdata_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Address phase is a pure decode of the state so it lasts exactly one cycle.
  always_comb begin
    master0.htrans = HTRANS_IDLE;
    master0.haddr  = '0;
    master0.hwrite = 1'b0;
    if (state_q == ST_W_ADDR || state_q == ST_R_ADDR) begin
      master0.htrans = HTRANS_NONSEQ;
      master0.haddr  = BASE_ADDR + {27'd0, idx_q, 2'b00};
      master0.hwrite = (state_q == ST_W_ADDR);
    end
  end

  assign master0.hsize  = HSIZE_WORD;
  assign master0.hwdata = hwdata_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign err            = err_q;
  assign res_valid      = res_valid_q;
  assign res_idx        = res_idx_q;
  assign res_data       = res_data_q;

endmodule

// File: tb/tb_fft8_ahb_master.sv
// Directed bench for fft8_ahb_master with a behavioural AHB-Lite target and result scoreboard.
module tb_fft8_ahb_master;
  import fft8_ahb_pkg::*;

  localparam logic [31:0] BASE = 32'h5000_0000;

  logic        pclk = 1'b0;
  logic        preset = 1'b0;
  logic        start = 1'b0;
  logic        load_we = 1'b0;
  logic [2:0]  load_idx = 3'd0;
  logic [31:0] load_data = 32'd0;
  logic        busy, done, err, res_valid;
  logic [2:0]  res_idx;
  logic [31:0] res_data;

  ahblite_interconnection bus ();

  fft8_ahb_master #(.BASE_ADDR(BASE), .WAIT_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
    .pclk      (pclk),
    .preset    (preset),
    .master0   (bus),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .load_we   (load_we),
    .load_idx  (load_idx),
    .load_data (load_data),
    .res_valid (res_valid),
    .res_idx   (res_idx),
    .res_data  (res_data)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Target model configuration, written only by the stimulus block
  int          wr_wait_slot = -1;
  int          rd_wait_slot = -1;
  int          rd_err_slot  = -1;
  bit          stuck        = 1'b0;
  logic [31:0] rd_mem [8];

  typedef struct {int cyc; logic wr; logic [31:0] addr;} aph_t;
  typedef struct {logic [2:0] idx; logic [31:0] data; int cyc;} res_t;
  aph_t        aph_q[$];
  logic [31:0] wdata_q[$];
  res_t        res_obs_q[$];
  bit          hw_unstable = 1'b0;
  int          done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
  logic        done_busy = 1'b0;

  // Target: decides hready/hresp/hrdata at the falling edge for the next rising edge
  bit          dp = 1'b0, dp_first = 1'b0, dp_wr = 1'b0;
  logic [2:0]  dp_slot = 3'd0;
  int          dp_wait = 0;
  logic [31:0] dp_hold = 32'd0;
  always @(negedge pclk) begin
    if (!preset) begin
      dp = 1'b0;
      bus.hready = 1'b1;
      bus.hresp  = 1'b0;
      bus.hrdata = 32'd0;
    end else if (dp) begin
      if (dp_first) begin dp_hold = bus.hwdata; dp_first = 1'b0; end
      if (dp_wr && bus.hwdata !== dp_hold) hw_unstable = 1'b1;
      if (stuck || dp_wait > 0) begin
        bus.hready = 1'b0;
        if (dp_wait > 0) dp_wait--;
      end else begin
        bus.hready = 1'b1;
        bus.hresp  = !dp_wr && (rd_err_slot == int'(dp_slot));
        bus.hrdata = dp_wr ? 32'd0 : rd_mem[dp_slot];
        if (dp_wr) wdata_q.push_back(bus.hwdata);
        dp = 1'b0;
      end
    end else begin
      bus.hready = 1'b1;
      bus.hresp  = 1'b0;
      if (bus.htrans == HTRANS_NONSEQ) begin
        aph_q.push_back('{cyc, bus.hwrite, bus.haddr});
        dp = 1'b1; dp_first = 1'b1; dp_wr = bus.hwrite; dp_slot = bus.haddr[4:2];
        dp_wait = ((bus.hwrite && wr_wait_slot == int'(dp_slot)) ||
                   (!bus.hwrite && rd_wait_slot == int'(dp_slot))) ? 3 : 0;
      end
    end
  end

  always @(negedge pclk) begin
    if (res_valid) res_obs_q.push_back('{res_idx, res_data, cyc});
    if (done) begin done_cnt++; done_cyc = cyc; done_busy = busy; end
    if (err) begin err_cnt++; err_cyc = cyc; end
  end

  int checks = 0, errors = 0;
  logic [31:0] buf_m [8];
  logic [32:0] exp_aph_q[$];
  logic [31:0] exp_wd_q[$];
  logic [34:0] exp_res_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [31:0] d);
    load_idx = 3'(i); load_data = d; load_we = 1'b1;
    @(negedge pclk);
    load_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge pclk); n++; end
    chk({tag, "_idle"}, 64'(busy), 64'(0));
    repeat (2) @(negedge pclk);
  endtask

  task automatic push_expect(input int n_wa, input int n_wd, input int n_ra, input int n_res);
    for (int i = 0; i < n_wa; i++) exp_aph_q.push_back({1'b1, BASE + 32'(i * 4)});
    for (int i = 0; i < n_wd; i++) exp_wd_q.push_back(buf_m[i]);
    for (int i = 0; i < n_ra; i++) exp_aph_q.push_back({1'b0, BASE + 32'(i * 4)});
    for (int i = 0; i < n_res; i++) exp_res_q.push_back({3'(i), rd_mem[i]});
  endtask

  task automatic score(input string tag, input int a0, input int w0, input int r0);
    int n;
    logic [63:0] o, e;
    n = exp_aph_q.size();
    chk({tag, "_aph_count"}, 64'(aph_q.size() - a0), 64'(n));
    for (int k = 0; k < n; k++) begin
      e = 64'(exp_aph_q.pop_front());
      o = (a0 + k < aph_q.size()) ? 64'({aph_q[a0 + k].wr, aph_q[a0 + k].addr}) : 'x;
      chk($sformatf("%s_aph%0d", tag, k), o, e);
    end
    n = exp_wd_q.size();
    chk({tag, "_wd_count"}, 64'(wdata_q.size() - w0), 64'(n));
    for (int k = 0; k < n; k++) begin
      e = 64'(exp_wd_q.pop_front());
      o = (w0 + k < wdata_q.size()) ? 64'(wdata_q[w0 + k]) : 'x;
      chk($sformatf("%s_hwdata%0d", tag, k), o, e);
    end
    n = exp_res_q.size();
    chk({tag, "_res_count"}, 64'(res_obs_q.size() - r0), 64'(n));
    for (int k = 0; k < n; k++) begin
      e = 64'(exp_res_q.pop_front());
      o = (r0 + k < res_obs_q.size()) ? 64'({res_obs_q[r0 + k].idx, res_obs_q[r0 + k].data}) : 'x;
      chk($sformatf("%s_res%0d", tag, k), o, e);
    end
  endtask

  initial begin
    int a0, w0, r0, d0, e0;

    // Reset state
    repeat (3) @(negedge pclk);
    chk("reset_ctrl", 64'({busy, done, err, res_valid, res_idx}), 64'(0));
    chk("reset_bus", 64'({bus.htrans, bus.hwrite, bus.hsize, bus.haddr}),
        64'({HTRANS_IDLE, 1'b0, 3'b010, 32'h0}));
    chk("reset_data", 64'({res_data, bus.hwdata}), 64'(0));
    preset = 1'b1;
    repeat (2) @(negedge pclk);

    // Run 1: ramp samples, zero-wait target, start/load during busy ignored
    for (int i = 0; i < 8; i++) begin
      buf_m[i] = {16'(i + 1), 16'(-i)};
      load(i, buf_m[i]);
      rd_mem[i] = 32'hA000_0000 + 32'(i * 32'h0101);
    end
    a0 = aph_q.size(); w0 = wdata_q.size(); r0 = res_obs_q.size(); d0 = done_cnt; e0 = err_cnt;
    push_expect(8, 8, 8, 8);
    pulse_start();
    chk("t1_busy_rise", 64'(busy), 64'(1));
    repeat (4) @(negedge pclk);
    start = 1'b1; load_we = 1'b1; load_idx = 3'd7; load_data = 32'hDEAD_BEEF;
    @(negedge pclk);
    start = 1'b0; load_we = 1'b0;
    wait_idle("t1", 200);
    score("t1", a0, w0, r0);
    chk("t1_first_read_lat", 64'(aph_q[a0 + 8].cyc - aph_q[a0].cyc), 64'(40));
    chk("t1_write_spacing", 64'(aph_q[a0 + 1].cyc - aph_q[a0].cyc), 64'(3));
    chk("t1_res_spacing", 64'(res_obs_q[r0 + 1].cyc - res_obs_q[r0].cyc), 64'(3));
    chk("t1_done_count", 64'(done_cnt - d0), 64'(1));
    chk("t1_err_count", 64'(err_cnt - e0), 64'(0));
    chk("t1_done_after_last", 64'(done_cyc - res_obs_q[r0 + 7].cyc), 64'(1));
    chk("t1_busy_at_done", 64'(done_busy), 64'(0));

    // Run 2: impulse, wait states on write 2 and read 5
    for (int i = 0; i < 8; i++) begin
      buf_m[i] = (i == 0) ? 32'h0100_0000 : 32'h0;
      load(i, buf_m[i]);
      rd_mem[i] = 32'h0100_0000;
    end
    wr_wait_slot = 2; rd_wait_slot = 5;
    a0 = aph_q.size(); w0 = wdata_q.size(); r0 = res_obs_q.size(); d0 = done_cnt;
    push_expect(8, 8, 8, 8);
    pulse_start();
    wait_idle("t2", 200);
    score("t2", a0, w0, r0);
    chk("t2_hwdata_stable", 64'(hw_unstable), 64'(0));
    chk("t2_first_read_lat", 64'(aph_q[a0 + 8].cyc - aph_q[a0].cyc), 64'(43));
    chk("t2_read_span", 64'(aph_q[a0 + 15].cyc - aph_q[a0 + 8].cyc), 64'(24));
    chk("t2_done_count", 64'(done_cnt - d0), 64'(1));
    wr_wait_slot = -1; rd_wait_slot = -1;

    // Run 3: error response on read 3
    for (int i = 0; i < 8; i++) rd_mem[i] = 32'h1234_0000 + 32'(i);
    rd_err_slot = 3;
    a0 = aph_q.size(); w0 = wdata_q.size(); r0 = res_obs_q.size(); d0 = done_cnt; e0 = err_cnt;
    push_expect(8, 8, 4, 3);
    pulse_start();
    wait_idle("t3", 200);
    score("t3", a0, w0, r0);
    chk("t3_err_count", 64'(err_cnt - e0), 64'(1));
    chk("t3_no_done", 64'(done_cnt - d0), 64'(0));
    chk("t3_htrans_idle", 64'(bus.htrans), 64'(HTRANS_IDLE));
    rd_err_slot = -1;

    // Run 4: hready stuck low on first write -> timeout
    stuck = 1'b1;
    a0 = aph_q.size(); w0 = wdata_q.size(); r0 = res_obs_q.size(); d0 = done_cnt; e0 = err_cnt;
    push_expect(1, 0, 0, 0);
    pulse_start();
    wait_idle("t4", 200);
    score("t4", a0, w0, r0);
    chk("t4_err_count", 64'(err_cnt - e0), 64'(1));
    chk("t4_timeout_cycle", 64'(err_cyc - aph_q[a0].cyc), 64'(65));
    chk("t4_no_done", 64'(done_cnt - d0), 64'(0));
    stuck = 1'b0;
    repeat (3) @(negedge pclk);

    // Run 5: clean rerun with start and load in the same cycle
    buf_m[0] = 32'h7FFF_8001;
    a0 = aph_q.size(); w0 = wdata_q.size(); r0 = res_obs_q.size(); d0 = done_cnt; e0 = err_cnt;
    push_expect(8, 8, 8, 8);
    load_idx = 3'd0; load_data = buf_m[0]; load_we = 1'b1;
    pulse_start();
    load_we = 1'b0;
    wait_idle("t5", 200);
    score("t5", a0, w0, r0);
    chk("t5_done_count", 64'(done_cnt - d0), 64'(1));
    chk("t5_err_count", 64'(err_cnt - e0), 64'(0));

    // Run 6: reset in the middle of the compute interval
    a0 = aph_q.size(); d0 = done_cnt;
    pulse_start();
    repeat (30) @(negedge pclk);
    chk("t6_writes_before_reset", 64'(aph_q.size() - a0), 64'(8));
    preset = 1'b0;
    @(negedge pclk);
    chk("t6_reset_ctrl", 64'({busy, done, err, res_valid, res_idx}), 64'(0));
    chk("t6_reset_bus", 64'({bus.htrans, bus.hwrite, bus.haddr}), 64'(0));
    chk("t6_reset_data", 64'({res_data, bus.hwdata}), 64'(0));
    preset = 1'b1;
    repeat (40) @(negedge pclk);
    chk("t6_no_done", 64'(done_cnt - d0), 64'(0));
    chk("t6_no_reads", 64'(aph_q.size() - a0), 64'(8));

    // Run 7: buffer was cleared by reset
    for (int i = 0; i < 8; i++) buf_m[i] = 32'h0;
    a0 = aph_q.size(); w0 = wdata_q.size(); r0 = res_obs_q.size(); d0 = done_cnt;
    push_expect(8, 8, 8, 8);
    pulse_start();
    wait_idle("t7", 200);
    score("t7", a0, w0, r0);
    chk("t7_done_count", 64'(done_cnt - d0), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
